// File: rtl/if_fetch_ctrl_pkg.sv
// Shared bus widths, control constants and fetch FSM encodings for if_fetch_ctrl.
// ROM_DPORT_EN adds the S_DATA state used by the optional ROM data port.
package if_fetch_ctrl_pkg;

  localparam int                  InstAddrBus = 32;
  localparam int                  InstBus     = 32;
  localparam logic [InstBus-1:0]  ZeroWord    = '0;
  localparam logic                ChipEnable  = 1'b1;
  localparam logic                ChipDisable = 1'b0;
  localparam logic                RstEnable   = 1'b1;

`ifdef ROM_DPORT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2,
    S_DATA = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } fetch_state_e;
`endif

  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
    return {a[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_fifo.sv
// if_fifo: synchronous fetch buffer holding {pc, inst} pairs, with a single-cycle flush.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module if_fifo
  import if_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: ROM sequencing, redirect handling and a small fetch buffer.
// Define ROM_DPORT_EN to add a data read port that shares the instruction ROM.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce,
  output logic [InstAddrBus-1:0] rom_addr,
  input  logic [InstBus-1:0]     rom_inst,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_inst,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc
`ifdef ROM_DPORT_EN
  ,
  input  logic                   d_req,
  input  logic [31:0]            d_addr,
  output logic [31:0]            d_rdata,
  output logic                   d_valid
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e   state_q;
  logic [31:0]    fpc_q;
  logic [CW-1:0]  count;
  logic [63:0]    head;
  logic           fifo_valid;
  logic           in_rst;
  logic           pop;
  logic           room;
  logic           dgrant;
  logic           fetch;
  logic           full_next;
  logic [31:0]    dport_addr;

  assign in_rst    = (rst == RstEnable);
  assign pop       = if_valid && if_ready;
  assign room      = (count < CW'(FIFO_DEPTH)) || pop;
  assign full_next = !pop && ((count + CW'(fetch)) == CW'(FIFO_DEPTH));

`ifdef ROM_DPORT_EN
  logic [31:0] d_rdata_q;
  logic        d_valid_q;
  // Back-off after a grant so fetch is never starved while it has room.
  assign dgrant     = !in_rst && d_req && !redirect && !(state_q == S_DATA && room);
  assign dport_addr = word_align(d_addr);
  assign d_rdata    = d_rdata_q;
  assign d_valid    = d_valid_q;
`else
  assign dgrant     = 1'b0;
  assign dport_addr = '0;
`endif

  assign fetch = !in_rst && !redirect && !dgrant && (state_q != S_IDLE) && room;

  always_comb begin
    rom_ce   = ChipDisable;
    rom_addr = fpc_q;
    if (in_rst) begin
      rom_addr = RESET_PC;
    end else if (dgrant) begin
      rom_ce   = ChipEnable;
      rom_addr = dport_addr;
    end else if (fetch) begin
      rom_ce   = ChipEnable;
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (!in_rst && redirect),
    .push_i  (fetch),
    .pop_i   (pop),
    .wdata_i ({fpc_q, rom_inst}),
    .rdata_o (head),
    .valid_o (fifo_valid),
    .count_o (count)
  );

  assign if_valid = fifo_valid && !in_rst;
  assign if_pc    = in_rst ? 32'h0 : head[63:32];
  assign if_inst  = in_rst ? ZeroWord : head[31:0];

  always_ff @(posedge clk) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      fpc_q   <= RESET_PC;
    end else if (redirect) begin
      state_q <= S_RUN;
      fpc_q   <= word_align(redirect_pc);
    end else begin
      if (fetch) fpc_q <= fpc_q + 32'd4;
`ifdef ROM_DPORT_EN
      if (dgrant) state_q <= S_DATA;
      else
`endif
      case (state_q)
        S_IDLE:  state_q <= S_RUN;
        S_FULL:  state_q <= pop ? S_RUN : S_FULL;
        default: state_q <= full_next ? S_FULL : S_RUN;
      endcase
    end
`ifdef ROM_DPORT_EN
    if (in_rst) begin
      d_valid_q <= 1'b0;
      d_rdata_q <= ZeroWord;
    end else begin
      d_valid_q <= dgrant;
      if (dgrant) d_rdata_q <= rom_inst;
    end
`endif
  end

endmodule
